mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch, load/store) onto one memory port: combinational grant, 1-cycle read data.
// Optional MEM_ARB_STARVE_EN promotes fetch over data after STARVE_LIMIT consecutive denied cycles.
module mem_arbiter #(
  parameter int ADDRWIDTH    = 32,
  parameter int DATAWIDTH    = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_req,
  input  logic [ADDRWIDTH-1:0] if_addr,
  output logic                 if_gnt,
  output logic [DATAWIDTH-1:0] if_rdata,
  output logic                 if_rvalid,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDRWIDTH-1:0] d_addr,
  input  logic [DATAWIDTH-1:0] d_wdata,
  output logic                 d_gnt,
  output logic [DATAWIDTH-1:0] d_rdata,
  output logic                 d_rvalid,
  output logic [ADDRWIDTH-1:0] mem_address,
  output logic                 mem_read_write,
  output logic [DATAWIDTH-1:0] mem_data_in,
  input  logic [DATAWIDTH-1:0] mem_data_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 d_rd_q, d_rd_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0] wdata_q, wdata_d;
  logic [DATAWIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATAWIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                 promote;

`ifdef MEM_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q, starve_d;

  assign promote = (starve_q == LIMIT);

  always_comb begin
    starve_d = starve_q;
    if (!if_req || if_gnt) begin
      starve_d = '0;
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  // Legal limits are non-negative, so fetch is never promoted in this build.
  assign promote = (STARVE_LIMIT < 0);
`endif

  // Grants are forced low while reset is asserted so no access can leak out.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (rst_n) begin
      if (d_req && !(promote && if_req)) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_address    = addr_q;
    mem_data_in    = wdata_q;
    mem_read_write = 1'b0;
    if (d_gnt) begin
      mem_address    = d_addr;
      mem_read_write = d_we;
      mem_data_in    = d_wdata;
    end else if (if_gnt) begin
      mem_address = if_addr;
      mem_data_in = d_wdata;
    end
    addr_d  = mem_address;
    wdata_d = mem_data_in;
  end

  always_comb begin
    state_d    = ST_IDLE;
    d_rd_d     = d_gnt && !d_we;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (d_gnt) begin
      state_d = ST_DATA;
    end else if (if_gnt) begin
      state_d = ST_FETCH;
    end
    if (if_gnt) begin
      if_rdata_d = mem_data_out;
    end
    if (d_rd_d) begin
      d_rdata_d = mem_data_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      d_rd_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      d_rd_q     <= d_rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign if_rvalid = (state_q == ST_FETCH);
  assign d_rvalid  = (state_q == ST_DATA) && d_rd_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule
